// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage with main+skid regs, flush, registered in_ready, occupancy level and saturating stall_cnt
module pipe_skid_reg #(
  parameter int DW = 38,
  parameter logic [DW-1:0] RST_VAL = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
  state_t state, state_n;
  logic [DW-1:0] main_data, skid_data;
  logic ld_main, ld_skid;
  assign out_valid = state != EMPTY;
  assign out_data = main_data;
  assign level = state;
  always_comb begin
    state_n = flush ? EMPTY
            : state == EMPTY ? (in_valid ? FULL : EMPTY)
            : state == FULL ? (in_valid && !out_ready ? SKID : !in_valid && out_ready ? EMPTY : FULL)
            : (out_ready ? FULL : SKID);
    ld_main = (state == EMPTY && in_valid) || (state == FULL && in_valid && out_ready) || (state == SKID && out_ready);
    ld_skid = state == FULL && in_valid && !out_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      main_data <= RST_VAL;
      skid_data <= RST_VAL;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      in_ready <= state_n != SKID;
      if (ld_main) main_data <= state == SKID ? skid_data : in_data;
      if (ld_skid) skid_data <= in_data;
      if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
